mem_io_responder: RTL
=====================

Name: mem_io_responder

Overview:
- Byte-wide memory/IO target that answers the CPU core's bus: mem_a, mem_dout, mem_wr, mem_din, io_buffer_full.
- Contains the RAM array and decodes the memory-mapped IO window.
- Buffers outgoing UART bytes and incoming UART bytes in FIFOs, keeps the cycle counter, and raises the program-stop flag.
- Sits between the CPU core and the UART/host-interface logic at chip top.

Parameters:
- RAM_ADDR_W, 17, RAM address bits; 128 KB, valid addresses 0x00000–0x1FFFF.
- TX_DEPTH_LOG, 4, log2 of TX FIFO depth (16 entries).
- RX_DEPTH_LOG, 4, log2 of RX FIFO depth (16 entries).

Ports:
- clk_in  in  1  system clock.
- rst_n_in  in  1  asynchronous, active-low reset.
- mem_a  in  32  byte address from the CPU.
- mem_dout  in  8  write data from the CPU.
- mem_wr  in  1  1 = write, 0 = read (a read is issued every cycle).
- mem_din  out  8  read data, valid one cycle after the address.
- io_buffer_full  out  1  TX FIFO nearly full; the CPU must hold IO writes.
- tx_data  out  8  byte to the UART transmitter.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  transmitter accepts the byte on tx_valid && tx_ready.
- rx_data  in  8  byte from the UART receiver.
- rx_valid  in  1  single-cycle strobe; rx_data valid.
- prog_stop  out  1  sticky; set by a write to 0x30004.

Behaviour:
- Reset: async on rst_n_in low. mem_din=0, io_buffer_full=0, tx_valid=0, prog_stop=0, both FIFOs empty, cycle counter=0. RAM contents are not reset.
- Address decode:
  - IO when mem_a[17:16]==2'b11.
  - RAM when mem_a[17]==0, indexed by mem_a[RAM_ADDR_W-1:0].
  - mem_a[31:18] is ignored.
  - 0x20000–0x2FFFF is unmapped: writes are dropped and reads return 0x00.
- RAM write: takes effect at the clock edge with mem_wr=1. A read of the same address in the next cycle returns the new byte.
- Read latency: exactly 1 cycle. mem_din is registered from the cycle-N address and presented in cycle N+1. During write cycles mem_din holds its previous value.
- Write to 0x30000:
  - Nonzero byte: pushed to the TX FIFO.
  - 0x00: ignored.
  - Push while the FIFO is full: byte dropped.
- Write to 0x30004: sets prog_stop and pushes 0x00 into the TX FIFO (end-of-output marker). Writes to 0x30001–0x30003 and 0x30005+ are ignored.
- Read of 0x30000:
  - RX FIFO non-empty: pops the head and returns it next cycle.
  - RX FIFO empty: returns 0x00 with no pop.
- Reads of 0x30004–0x30007:
  - Return bytes 0–3 (little-endian) of the 32-bit cycle snapshot.
  - A read of 0x30004 loads the snapshot from the live counter; 0x30005–0x30007 read the held snapshot, so a 4-byte load is coherent.
- Other IO reads: 0x00.
- Cycle counter: 32-bit free-running, increments every cycle after reset, wraps 0xFFFFFFFF→0.
- TX FIFO:
  - tx_valid = non-empty; tx_data = head.
  - Pop on tx_valid && tx_ready.
  - Simultaneous push and pop: count unchanged, both take effect.
- io_buffer_full: registered, 1 when TX count ≥ 2^TX_DEPTH_LOG − 2. The margin absorbs the CPU's one in-flight write.
- RX FIFO:
  - Push on rx_valid.
  - When full, the incoming byte is dropped.
  - Simultaneous push and pop is allowed.
- Reset mid-transfer: both FIFOs are flushed and any pending read data is lost.

Optional Feature:
- Macro: MEM_IO_OOB_TRAP_EN.
- Enabled:
  - An access to 0x20000–0x2FFFF, or a write to a reserved IO address, sets a sticky output oob_err (1 bit, reset 0).
  - Reads from 0x20000–0x2FFFF return 0xEE.
- Disabled: the port is absent and unmapped reads return 0x00.

Decomposition:
- Shared package mem_io_pkg:
  - Constants: IO_SEL (2'b11), ADDR_IO_DATA (0x30000), ADDR_IO_CLK (0x30004), RAM_LIMIT (0x20000).
  - Read-source select enum: RD_RAM, RD_RX, RD_CLK, RD_ZERO. This is registered for one cycle to steer mem_din.
- Sub-module: byte_fifo.
  - Parameterised depth, push/pop, full/empty/count.
  - Instantiated twice, for TX and RX.

Test Plan:
- RAM: write 0xA5 @0x00010, read 0x00010 next cycle → mem_din=0xA5 one cycle later. Read 0x1FFFF after writing 0x3C → 0x3C.
- TX path:
  - With tx_ready=0, write 0x41, 0x00, 0x42 to 0x30000 → FIFO count 2 (0x00 ignored).
  - Raise tx_ready → tx_data 0x41 then 0x42, tx_valid then drops.
- Backpressure: tx_ready=0, write 14 nonzero bytes → io_buffer_full=1 after the 14th. A 17th write is dropped, and the FIFO drains exactly 16 bytes.
- Stop: write 0x30004 → prog_stop=1 next cycle and 0x00 emitted on tx_data. Assert rst_n_in low mid-drain → tx_valid=0 and prog_stop=0 immediately.
- RX: strobe rx_valid with 0x55, 0x66 → reads of 0x30000 return 0x55, 0x66, then 0x00 on empty.
- Clock: read 0x30004..0x30007 on consecutive cycles → the four bytes reassemble to the counter value latched at the 0x30004 read. Force the counter to 0xFFFFFFFF → next value is 0.

Source files
------------

// File: rtl/mem_io_pkg.sv
// Shared constants and read-source encoding for the mem_io_responder slice.
// The trap build (MEM_IO_OOB_TRAP_EN) uses the same constants.
package mem_io_pkg;

  localparam logic [1:0]  IO_SEL       = 2'b11;
  localparam logic [17:0] ADDR_IO_DATA = 18'h30000;
  localparam logic [17:0] ADDR_IO_CLK  = 18'h30004;
  localparam logic [17:0] RAM_LIMIT    = 18'h20000;

  // Captured on each read cycle; steers mem_din during the following cycle.
  typedef enum logic [1:0] {
    RD_RAM,
    RD_RX,
    RD_CLK,
    RD_ZERO
  } rd_sel_t;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with combinational head, used for both UART directions.
// Pushes into a full FIFO are dropped; pops from an empty FIFO are ignored.
module byte_fifo #(
  parameter int DEPTH_LOG = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 push,
  input  logic [7:0]           push_data,
  input  logic                 pop,
  output logic [7:0]           head,
  output logic                 full,
  output logic                 empty,
  output logic [DEPTH_LOG:0]   count,
  output logic [DEPTH_LOG:0]   count_next
);
  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] FULL_CNT = {1'b1, {DEPTH_LOG{1'b0}}};

  logic [7:0]           mem_reg [DEPTH];
  logic [DEPTH_LOG-1:0] wr_ptr_reg;
  logic [DEPTH_LOG-1:0] rd_ptr_reg;
  logic [DEPTH_LOG:0]   count_reg;
  logic                 push_ok;
  logic                 pop_ok;

  assign full    = count_reg == FULL_CNT;
  assign empty   = count_reg == '0;
  assign count   = count_reg;
  assign head    = mem_reg[rd_ptr_reg];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    count_next = count_reg;
    if (push_ok && !pop_ok) begin
      count_next = count_reg + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_next = count_reg - 1'b1;
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk_in) begin
    if (push_ok) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// Byte-wide RAM plus memory-mapped UART/cycle-counter IO target for the CPU bus.
// Define MEM_IO_OOB_TRAP_EN to add the sticky oob_err output and 0xEE unmapped reads.
module mem_io_responder
  import mem_io_pkg::*;
#(
  parameter int RAM_ADDR_W   = 17,
  parameter int TX_DEPTH_LOG = 4,
  parameter int RX_DEPTH_LOG = 4
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
`ifdef MEM_IO_OOB_TRAP_EN
  output logic        oob_err,
`endif
  output logic        prog_stop
);
  localparam int TX_HIGH_WATER = (1 << TX_DEPTH_LOG) - 2;

  logic [17:0] addr;
  logic        addr_hi_unused;
  logic        is_ram, is_io, is_unmapped, is_data, is_clk, is_clk_win;

  assign addr           = mem_a[17:0];
  assign addr_hi_unused = ^mem_a[31:18];
  assign is_ram         = addr < RAM_LIMIT;
  assign is_io          = addr[17:16] == IO_SEL;
  assign is_unmapped    = !is_ram && !is_io;
  assign is_data        = addr == ADDR_IO_DATA;
  assign is_clk         = addr == ADDR_IO_CLK;
  assign is_clk_win     = addr[17:2] == ADDR_IO_CLK[17:2];

  // RAM with read enable: the read register only moves on read cycles so that
  // mem_din holds across CPU write cycles.
  logic [7:0] ram_mem [1 << RAM_ADDR_W];
  logic [7:0] ram_rd_reg;

  always_ff @(posedge clk_in) begin
    if (mem_wr && is_ram) begin
      ram_mem[addr[RAM_ADDR_W-1:0]] <= mem_dout;
    end
    if (!mem_wr) begin
      ram_rd_reg <= ram_mem[addr[RAM_ADDR_W-1:0]];
    end
  end

  logic                  tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]            tx_push_data;
  logic [TX_DEPTH_LOG:0] tx_count, tx_count_next;
  logic                  rx_pop, rx_full, rx_empty;
  logic [7:0]            rx_head;
  logic [RX_DEPTH_LOG:0] rx_count, rx_count_next;
  logic                  fifo_status_unused;

  // The stop write doubles as an end-of-output marker for the host.
  assign tx_push      = mem_wr && (is_clk || (is_data && mem_dout != 8'h00));
  assign tx_push_data = is_clk ? 8'h00 : mem_dout;
  assign tx_valid     = !tx_empty;
  assign tx_pop       = tx_valid && tx_ready;
  assign rx_pop       = !mem_wr && is_data && !rx_empty;
  assign fifo_status_unused = ^{tx_full, tx_count, rx_full, rx_count, rx_count_next};

  byte_fifo #(.DEPTH_LOG(TX_DEPTH_LOG)) u_tx_fifo (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .push       (tx_push),
    .push_data  (tx_push_data),
    .pop        (tx_pop),
    .head       (tx_data),
    .full       (tx_full),
    .empty      (tx_empty),
    .count      (tx_count),
    .count_next (tx_count_next)
  );

  byte_fifo #(.DEPTH_LOG(RX_DEPTH_LOG)) u_rx_fifo (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .push       (rx_valid),
    .push_data  (rx_data),
    .pop        (rx_pop),
    .head       (rx_head),
    .full       (rx_full),
    .empty      (rx_empty),
    .count      (rx_count),
    .count_next (rx_count_next)
  );

  rd_sel_t     rd_sel_reg;
  logic [7:0]  rx_byte_reg;
  logic [7:0]  clk_byte_reg;
  logic [31:0] snap_reg;
  logic [31:0] cycle_cnt_reg;
  logic        prog_stop_reg;
  logic        io_full_reg;
  logic [7:0]  snap_byte [4];
  logic [7:0]  zero_byte;

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_snap_byte
    assign snap_byte[gi] = snap_reg[8*gi +: 8];
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rd_sel_reg    <= RD_ZERO;
      rx_byte_reg   <= '0;
      clk_byte_reg  <= '0;
      snap_reg      <= '0;
      cycle_cnt_reg <= '0;
      prog_stop_reg <= 1'b0;
      io_full_reg   <= 1'b0;
    end else begin
      cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
      // Based on next count so the flag tracks the FIFO edge-for-edge.
      io_full_reg   <= 32'(tx_count_next) >= TX_HIGH_WATER;
      if (mem_wr && is_clk) begin
        prog_stop_reg <= 1'b1;
      end
      if (!mem_wr) begin
        if (is_ram) begin
          rd_sel_reg <= RD_RAM;
        end else if (is_data) begin
          rd_sel_reg  <= RD_RX;
          rx_byte_reg <= rx_empty ? 8'h00 : rx_head;
        end else if (is_clk_win) begin
          rd_sel_reg <= RD_CLK;
          // Byte 0 latches the whole counter so bytes 1..3 come from one instant.
          if (is_clk) begin
            snap_reg     <= cycle_cnt_reg;
            clk_byte_reg <= cycle_cnt_reg[7:0];
          end else begin
            clk_byte_reg <= snap_byte[addr[1:0]];
          end
        end else begin
          rd_sel_reg <= RD_ZERO;
        end
      end
    end
  end

`ifdef MEM_IO_OOB_TRAP_EN
  logic oob_err_reg;
  logic oob_rd_reg;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      oob_err_reg <= 1'b0;
      oob_rd_reg  <= 1'b0;
    end else begin
      if (is_unmapped || (mem_wr && is_io && !is_data && !is_clk)) begin
        oob_err_reg <= 1'b1;
      end
      if (!mem_wr) begin
        oob_rd_reg <= is_unmapped;
      end
    end
  end

  assign oob_err   = oob_err_reg;
  assign zero_byte = oob_rd_reg ? 8'hEE : 8'h00;
`else
  assign zero_byte = 8'h00;
`endif

  always_comb begin
    mem_din = zero_byte;
    case (rd_sel_reg)
      RD_RAM:  mem_din = ram_rd_reg;
      RD_RX:   mem_din = rx_byte_reg;
      RD_CLK:  mem_din = clk_byte_reg;
      RD_ZERO: mem_din = zero_byte;
      default: mem_din = zero_byte;
    endcase
  end

  assign io_buffer_full = io_full_reg;
  assign prog_stop      = prog_stop_reg;

endmodule
